rom_loader_avm: RTL and testbench
=================================

# rom_loader_avm

Avalon-MM master that loads the 1024×32 boot ROM of the PicoRV32 SoC from a byte stream (UART receive path) and then verifies the load by reading it back. Drives the ROM slave's write path (chipselect & write & debugaccess) to load, then its read path for a checksum compare. Sits between the serial receiver and the ROM's s1 slave port, ahead of CPU reset release.

## Interface
Parameters:
- ADDR_WIDTH, 10, ROM word-address width
- DEPTH, 1024, ROM depth in 32-bit words

Ports:
- clk  input  1  system clock
- reset  input  1  asynchronous, active-high reset
- start  input  1  one-cycle pulse; begins a load
- load_words  input  ADDR_WIDTH+1  number of words to load, sampled on start
- in_data  input  8  stream byte, little-endian within each word
- in_valid  input  1  in_data valid
- in_ready  output  1  block accepts byte this cycle
- busy  output  1  load or verify in progress
- done  output  1  one-cycle pulse at end of verify
- error  output  1  checksum mismatch of last load; held until next accepted start
- avm_address  output  ADDR_WIDTH  ROM word address
- avm_byteenable  output  4  byte enables
- avm_chipselect  output  1  ROM chip select
- avm_write  output  1  write strobe
- avm_debugaccess  output  1  write-enable qualifier for ROM
- avm_writedata  output  32  write data
- avm_readdata  input  32  ROM read data (valid one cycle after address is presented)
- avm_clken  output  1  ROM clock enable, constant 1

## Operation
- States: IDLE, COLLECT, WRITE, VERIFY, CHECK.
- IDLE: in_ready=0, busy=0. start latches N=min(load_words, DEPTH), clears error, word index, byte counter, and 32-bit sum. N=0 -> go straight to CHECK (compares 0 with 0). Otherwise -> COLLECT.
- COLLECT: in_ready=1. Each accepted byte (in_valid & in_ready) is shifted into bits [8k+7:8k] for byte k=0..3. After byte 3 -> WRITE.
- WRITE: one cycle with avm_chipselect=1, avm_write=1, avm_debugaccess=1, avm_byteenable=4'hF, avm_address=word index, avm_writedata=assembled word. sum += word (mod 2^32). If index==N-1 -> VERIFY with index reset to 0, else index+1 -> COLLECT.
- VERIFY: avm_chipselect=1, avm_write=0, avm_debugaccess=0, avm_address=index, incrementing every cycle for N cycles. avm_readdata is sampled one cycle after each address and added to a readback sum (mod 2^32). After the last address, one extra cycle samples the final word -> CHECK.
- CHECK: one cycle; error <= (readback sum != write sum); done=1; -> IDLE.
- start while busy is ignored. in_valid outside COLLECT is ignored (not consumed).
- Outside WRITE/VERIFY: avm_chipselect, avm_write, avm_debugaccess=0; avm_byteenable=4'hF; avm_address, avm_writedata hold last value.

## Timing
- Reset values: in_ready=0, busy=0, done=0, error=0, avm_address=0, avm_byteenable=4'hF, avm_chipselect=0, avm_write=0, avm_debugaccess=0, avm_writedata=0, avm_clken=1; state IDLE; sums zero.
- All outputs registered except in_ready, which is decoded from state.
- COLLECT entered the cycle after start; WRITE the cycle after the 4th byte handshake. No byte is accepted during WRITE.
- Minimum load time for N words: 5N cycles (back-to-back bytes) + N+1 verify + 1 check.
- Verify read is fully pipelined: one address per cycle, no waitrequest (ROM has none).
- Reset mid-operation: immediate return to IDLE with reset values; partially written ROM contents are not restored; no done pulse.
- load_words > DEPTH: clamps to DEPTH; excess stream bytes are left unconsumed.

## Test plan
- Reset: assert reset mid-COLLECT -> all outputs at reset values next cycle, in_ready=0, busy=0.
- Load N=2, bytes 78 56 34 12 EF BE AD DE -> writes 0x12345678 @0 and 0xDEADBEEF @1, each with byteenable F and debugaccess=1; verify reads addr 0,1; done pulse, error=0.
- Load N=1 with ROM model corrupting readback of addr 0 (bit 0 flipped) -> done pulse, error=1; next start clears error.
- Load N=0 -> no avm_write, done pulse 2 cycles after start, error=0.
- Gapped stream (in_valid toggling every other cycle), N=3 -> identical write sequence, bytes never dropped or duplicated; start pulses during busy ignored.
- load_words=1100 -> exactly 1024 writes, addresses 0..1023, no address wrap, in_ready=0 after last word.

Source files
------------

// File: rtl/rom_loader_avm.sv
// rom_loader_avm: loads the boot ROM over Avalon-MM from a byte stream, then verifies it by checksum readback
module rom_loader_avm #(
  parameter int ADDR_WIDTH = 10,
  parameter int DEPTH = 1024
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [ADDR_WIDTH:0]   load_words,
  input  logic [7:0]            in_data,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic                  busy,
  output logic                  done,
  output logic                  error,
  output logic [ADDR_WIDTH-1:0] avm_address,
  output logic [3:0]            avm_byteenable,
  output logic                  avm_chipselect,
  output logic                  avm_write,
  output logic                  avm_debugaccess,
  output logic [31:0]           avm_writedata,
  input  logic [31:0]           avm_readdata,
  output logic                  avm_clken
);
  typedef enum logic [2:0] {IDLE, COLLECT, WRITE, VERIFY, CHECK} state_t;
  localparam logic [ADDR_WIDTH:0] DEPTH_W = (ADDR_WIDTH+1)'(DEPTH);
  localparam logic [ADDR_WIDTH:0] ONE = (ADDR_WIDTH+1)'(1);
  state_t state;
  logic [ADDR_WIDTH:0] n;
  logic [ADDR_WIDTH:0] idx;
  logic [1:0] bcnt;
  logic [23:0] word;
  logic [31:0] wsum;
  logic [31:0] rsum;
  assign in_ready = state == COLLECT;
  assign avm_clken = 1'b1;
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state <= IDLE;
      n <= '0;
      idx <= '0;
      bcnt <= '0;
      word <= '0;
      wsum <= '0;
      rsum <= '0;
      busy <= 1'b0;
      done <= 1'b0;
      error <= 1'b0;
      avm_address <= '0;
      avm_byteenable <= 4'hF;
      avm_chipselect <= 1'b0;
      avm_write <= 1'b0;
      avm_debugaccess <= 1'b0;
      avm_writedata <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: if (start) begin
          n <= load_words > DEPTH_W ? DEPTH_W : load_words;
          error <= 1'b0;
          idx <= '0;
          bcnt <= '0;
          wsum <= '0;
          rsum <= '0;
          busy <= 1'b1;
          state <= load_words == 0 ? CHECK : COLLECT;
        end
        COLLECT: if (in_valid) begin
          // little-endian: earlier bytes slide toward the low end
          word <= {in_data, word[23:8]};
          bcnt <= bcnt + 2'd1;
          if (bcnt == 2'd3) begin
            avm_writedata <= {in_data, word};
            avm_address <= idx[ADDR_WIDTH-1:0];
            avm_chipselect <= 1'b1;
            avm_write <= 1'b1;
            avm_debugaccess <= 1'b1;
            state <= WRITE;
          end
        end
        WRITE: begin
          avm_write <= 1'b0;
          avm_debugaccess <= 1'b0;
          wsum <= wsum + avm_writedata;
          if (idx == n - ONE) begin
            idx <= '0;
            avm_address <= '0;
            state <= VERIFY;
          end else begin
            avm_chipselect <= 1'b0;
            idx <= idx + ONE;
            state <= COLLECT;
          end
        end
        VERIFY: begin
          // idx counts addresses already presented; data lags address by one cycle
          idx <= idx + ONE;
          if (idx != 0) rsum <= rsum + avm_readdata;
          if (idx + ONE < n) avm_address <= avm_address + ADDR_WIDTH'(1);
          else avm_chipselect <= 1'b0;
          if (idx == n) state <= CHECK;
        end
        CHECK: begin
          error <= rsum != wsum;
          done <= 1'b1;
          busy <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
endmodule

// File: tb/tb_rom_loader_avm.sv
// tb_rom_loader_avm: directed checks of rom_loader_avm against a 1024x32 ROM model
module tb_rom_loader_avm;
  logic clk = 0, reset = 1, start = 0, in_valid = 0, corrupt = 0;
  logic [10:0] load_words = '0;
  logic [7:0] in_data = '0;
  logic in_ready, busy, done, error, avm_chipselect, avm_write, avm_debugaccess, avm_clken;
  logic [9:0] avm_address;
  logic [3:0] avm_byteenable;
  logic [31:0] avm_writedata;
  logic [31:0] avm_readdata = '0;
  logic [31:0] mem [1024];
  logic [9:0] wa [$];
  logic [9:0] ra [$];
  logic [31:0] wd [$];
  int bad_wr = 0, n_chk = 0, n_pass = 0;

  always #5 clk = ~clk;

  rom_loader_avm dut (
    .clk(clk), .reset(reset), .start(start), .load_words(load_words),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .busy(busy), .done(done), .error(error),
    .avm_address(avm_address), .avm_byteenable(avm_byteenable),
    .avm_chipselect(avm_chipselect), .avm_write(avm_write),
    .avm_debugaccess(avm_debugaccess), .avm_writedata(avm_writedata),
    .avm_readdata(avm_readdata), .avm_clken(avm_clken)
  );

  always @(posedge clk) begin
    if (avm_chipselect && avm_write) begin
      mem[avm_address] <= avm_writedata;
      wa.push_back(avm_address);
      wd.push_back(avm_writedata);
      if (avm_byteenable != 4'hF || !avm_debugaccess) bad_wr++;
    end
    if (avm_chipselect && !avm_write) ra.push_back(avm_address);
    avm_readdata <= mem[avm_address] ^ {31'd0, corrupt && avm_address == 10'd0};
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic chk_rst(input string tag);
    chk(tag, {in_ready, busy, done, error, avm_chipselect, avm_write, avm_debugaccess,
              avm_clken, avm_byteenable, avm_address, avm_writedata},
        {7'b0, 1'b1, 4'hF, 10'd0, 32'd0});
  endtask

  task automatic do_start(input logic [10:0] n);
    start = 1;
    load_words = n;
    @(negedge clk);
    start = 0;
  endtask

  task automatic send_byte(input logic [7:0] b, input bit gap);
    int t = 0;
    in_data = b;
    in_valid = 1;
    while (!in_ready && t < 50) begin @(negedge clk); t++; end
    if (!in_ready) chk("byte_wait", in_ready, 1);
    @(negedge clk);
    in_valid = 0;
    if (gap) @(negedge clk);
  endtask

  task automatic wait_done(input string tag, input int budget);
    int t = 0;
    while (!done && t < budget) begin @(negedge clk); t++; end
    chk(tag, done, 1);
  endtask

  task automatic clear_log();
    wa.delete();
    wd.delete();
    ra.delete();
    bad_wr = 0;
  endtask

  initial begin
    logic [7:0] s2 [8] = '{8'h78, 8'h56, 8'h34, 8'h12, 8'hEF, 8'hBE, 8'hAD, 8'hDE};
    logic [7:0] s4 [4] = '{8'h01, 8'h02, 8'h03, 8'h04};
    int bad;
    repeat (2) @(negedge clk);
    chk_rst("por_outs");
    reset = 0;
    @(negedge clk);
    do_start(11'd2);
    send_byte(8'h78, 0);
    send_byte(8'h56, 0);
    chk("mid_collect_ready", in_ready, 1);
    reset = 1;
    #1;
    chk_rst("rst_mid_collect");
    @(negedge clk);
    chk("rst_no_done", done, 0);
    reset = 0;
    @(negedge clk);

    clear_log();
    do_start(11'd2);
    for (int i = 0; i < 8; i++) send_byte(s2[i], 0);
    wait_done("n2_done", 100);
    chk("n2_err", error, 0);
    chk("n2_wcount", wa.size(), 2);
    chk("n2_w0", {wa[0], wd[0]}, {10'd0, 32'h12345678});
    chk("n2_w1", {wa[1], wd[1]}, {10'd1, 32'hDEADBEEF});
    chk("n2_wflags", bad_wr, 0);
    chk("n2_reads", {ra.size(), ra[0], ra[1]}, {32'd2, 10'd0, 10'd1});
    @(negedge clk);
    chk("n2_done_pulse", {done, busy}, 2'b00);

    clear_log();
    corrupt = 1;
    do_start(11'd1);
    for (int i = 0; i < 4; i++) send_byte(s4[i], 0);
    wait_done("corrupt_done", 100);
    chk("corrupt_err", error, 1);
    chk("corrupt_w0", {wa[0], wd[0]}, {10'd0, 32'h04030201});
    corrupt = 0;
    @(negedge clk);

    clear_log();
    do_start(11'd0);
    chk("n0_err_clr", {error, done, busy}, 3'b001);
    @(negedge clk);
    chk("n0_done", {done, busy, error}, 3'b100);
    chk("n0_nowrite", wa.size(), 0);
    @(negedge clk);

    clear_log();
    do_start(11'd3);
    for (int i = 0; i < 12; i++) begin
      send_byte(8'(8'h11 * (i + 1)), 1);
      if (i == 5) begin start = 1; load_words = 11'd1; @(negedge clk); start = 0; end
    end
    start = 1;
    @(negedge clk);
    start = 0;
    wait_done("gap_done", 100);
    chk("gap_err", error, 0);
    chk("gap_wcount", wa.size(), 3);
    chk("gap_w0", {wa[0], wd[0]}, {10'd0, 32'h44332211});
    chk("gap_w1", {wa[1], wd[1]}, {10'd1, 32'h88776655});
    chk("gap_w2", {wa[2], wd[2]}, {10'd2, 32'hCCBBAA99});
    chk("gap_mem2", mem[2], 32'hCCBBAA99);
    chk("gap_wflags", bad_wr, 0);
    @(negedge clk);

    clear_log();
    do_start(11'd1100);
    for (int i = 0; i < 4096; i++) send_byte(8'(i), 0);
    chk("big_ready_after_last", in_ready, 0);
    wait_done("big_done", 2000);
    chk("big_err", error, 0);
    chk("big_wcount", wa.size(), 1024);
    chk("big_rcount", ra.size(), 1024);
    bad = 0;
    for (int k = 0; k < wa.size(); k++)
      if (int'(wa[k]) != k || wd[k] != {8'(4*k+3), 8'(4*k+2), 8'(4*k+1), 8'(4*k)}) bad++;
    chk("big_seq", bad, 0);
    chk("big_wflags", bad_wr, 0);
    in_valid = 1;
    repeat (3) @(negedge clk);
    chk("big_idle", {in_ready, busy}, 2'b00);
    in_valid = 0;

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
